uart_baud_gen_frac: RTL and testbench
=====================================

Name: uart_baud_gen_frac

Overview:
Parametrised successor to the fixed 13-bit baud clock generator. It produces an oversampled baud tick and a bit-boundary tick for UART TX/RX.
- Fractional divide uses an N-bit phase accumulator instead of 3-bit fraction lookup cases.
- Oversample ratio is programmable.
- Configuration is double-buffered and applied glitch-free at bit boundaries.
- A resync input lets the RX path realign on a start bit.

Parameters:
CNT_W, 16, width of integer divisor.
FRAC_W, 4, width of fractional divisor (resolution 1/2^FRAC_W cycle).
OSR_W, 5, width of oversample-ratio field (ratio = cfg_osr+1, max 2^OSR_W).

Ports:
clk  in  1  system clock
aresetn  in  1  reset, asynchronous, active-low
enable  in  1  run generator; low = hold cleared, no ticks
cfg_int  in  CNT_W  integer divisor; tick period = cfg_int+1 cycles (+fraction)
cfg_frac  in  FRAC_W  fractional divisor numerator
cfg_osr  in  OSR_W  oversample ratio minus 1 (15 = x16)
cfg_load  in  1  1-cycle strobe: capture cfg_* into shadow
cfg_ack  out  1  1-cycle pulse: shadow applied to active config
resync  in  1  1-cycle strobe: restart divider and phase
baud_tick  out  1  registered 1-cycle oversample tick
bit_tick  out  1  registered 1-cycle tick, subset of baud_tick, once per osr+1 baud_ticks
tick_phase  out  OSR_W  current oversample phase, 0 during bit_tick cycle

Behaviour:
- Reset values: all outputs 0. cnt, acc, stretch, phase, active config, shadow and pending are all 0.
- cfg_load captures cfg_int, cfg_frac and cfg_osr into the shadow and sets pending. A later load overwrites the shadow.
- Enable low, each edge:
  - cnt<=active_int.
  - acc, stretch and phase<=0.
  - No ticks.
  - If pending, active<=shadow, pending<=0, cfg_ack<=1.
- Enable high, cnt!=0: cnt<=cnt-1, baud_tick<=0.
- Enable high, cnt==0, stretch==0:
  - {carry,sum}=acc+active_frac, computed in FRAC_W+1 bits; acc<=sum.
  - carry=1: stretch<=1, cnt held at 0, no tick.
  - carry=0: tick edge.
- Enable high, cnt==0, stretch==1: stretch<=0, tick edge.
- Tick edge:
  - baud_tick<=1, cnt<=active_int.
  - If phase==active_osr: phase<=0, bit_tick<=1. Otherwise phase<=phase+1, bit_tick<=0.
- Bit-boundary apply: on a tick edge with phase==active_osr and pending set:
  - active<=shadow, cnt<=shadow_int, acc<=0, pending<=0.
  - cfg_ack<=1, so cfg_ack is coincident with bit_tick.
  - The next period already uses the new divisor.
- Tick period is active_int+1 cycles, or +2 when carry. Average period is active_int+1+active_frac/2^FRAC_W cycles. Fraction 0 gives an exact integer period.
- Integer divisor 0 with fraction 0 gives baud_tick every cycle.
- Phase wraps at active_osr. Osr 0 makes every baud_tick a bit_tick.
- Resync (enable high) has priority over the counting rules:
  - cnt<=active_int; acc, stretch and phase<=0; ticks<=0.
  - If pending: apply shadow (cnt<=shadow_int) and pulse cfg_ack.
  - First baud_tick is cnt+1 cycles after the resync cycle.
- cfg_load coincident with an apply edge (boundary, resync or disabled): the old shadow is applied. The new value is captured and pending stays 1 for the next boundary.
- An active_osr change never leaves phase > osr: phase is cleared on apply (apply only occurs at wrap, resync or disable).
- aresetn asserted mid-operation clears everything immediately. There is no partial tick.
- Ticks are registered. baud_tick and bit_tick change only on clk edges, with no combinational path from inputs.

Test Plan:
1. cfg_int=4, frac=0, osr=15, load, enable -> cfg_ack within 1 cycle (disabled apply); baud_tick every 5 cycles; bit_tick every 80 cycles with tick_phase=0; tick_phase counts 0..15.
2. cfg_int=4, frac=8 (FRAC_W=4) -> tick periods alternate 5,6; 16 baud_ticks in exactly 88 cycles. Then frac=1 -> 16 baud_ticks in 81 cycles, exactly one 6-cycle period.
3. Running at int=4, osr=15; load int=9 at tick_phase=5 -> periods stay 5 until the next bit_tick. cfg_ack is coincident with that bit_tick; following periods are 10 cycles.
4. resync asserted with cnt=2, phase=7 (int=4) -> next baud_tick exactly 5 cycles after the resync cycle, with tick_phase=1 in the cycle after that tick. A pending config is applied and cfg_ack pulses at the resync edge.
5. cfg_load (int=7) in the same cycle as a bit-boundary apply of a pending int=3 -> int=3 active and cfg_ack pulses. int=7 is applied at the following bit_tick with a second cfg_ack.
6. aresetn low mid-period with pending set; enable low for 3 cycles -> all outputs 0, no cfg_ack after reset release; with enable low, no baud_tick.

Source files
------------

// File: rtl/uart_baud_gen_frac_if.sv
// Bundle of control, configuration and tick signals for the fractional
// baud generator. The controller side (UART TX/RX block or a bench) uses
// the master modport; the generator itself uses the slave modport.
//
// Configuration handshake: cfg_load is a one-cycle strobe that is always
// accepted (there is no back-pressure). The values on cfg_int, cfg_frac and
// cfg_osr are sampled on that edge into a shadow. cfg_ack is a one-cycle
// completion pulse that is raised on the edge where the shadow becomes the
// active configuration. A second cfg_load before cfg_ack simply replaces the
// shadow, and only one cfg_ack is produced for it.
interface uart_baud_gen_frac_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 5
);
    logic              enable;
    logic [CNT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic [OSR_W-1:0]  cfg_osr;
    logic              cfg_load;
    logic              cfg_ack;
    logic              resync;
    logic              baud_tick;
    logic              bit_tick;
    logic [OSR_W-1:0]  tick_phase;

    modport master (
        output enable, cfg_int, cfg_frac, cfg_osr, cfg_load, resync,
        input  cfg_ack, baud_tick, bit_tick, tick_phase
    );

    modport slave (
        input  enable, cfg_int, cfg_frac, cfg_osr, cfg_load, resync,
        output cfg_ack, baud_tick, bit_tick, tick_phase
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud tick generator. An integer down-counter sets the base
// period (cfg_int+1 cycles). A FRAC_W-bit phase accumulator adds one extra
// cycle whenever it overflows, which gives an average period of
// cfg_int+1+cfg_frac/2^FRAC_W. Every (cfg_osr+1)-th baud tick is also a
// bit tick. New configuration waits in a shadow and only becomes active at
// a bit boundary, a resync, or while disabled, so a running bit is never
// cut short or stretched by a reconfiguration.
module uart_baud_gen_frac #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 5
) (
    input  logic                 clk,
    input  logic                 aresetn,
    uart_baud_gen_frac_if.slave  bus
);

    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              stretch;
    logic [OSR_W-1:0]  phase;

    logic [CNT_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [OSR_W-1:0]  act_osr;

    logic [CNT_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;
    logic [OSR_W-1:0]  sh_osr;
    logic              pending;

    logic              cfg_ack_q;
    logic              baud_q;
    logic              bit_q;

    // Next-step decode: accumulator sum, tick edge, bit boundary, apply.
    logic [FRAC_W:0]   acc_sum;
    logic              tick_edge;
    logic              wrap;
    logic              apply;

    // Decide whether this edge ticks, wraps the phase and applies the shadow.
    always_comb begin
        acc_sum   = {1'b0, acc} + {1'b0, act_frac};
        tick_edge = 1'b0;
        if (bus.enable && !bus.resync && (cnt == '0)) begin
            // A pending stretch cycle always ends in a tick; otherwise tick
            // unless the accumulator overflows and asks for one more cycle.
            tick_edge = stretch || !acc_sum[FRAC_W];
        end
        wrap  = tick_edge && (phase == act_osr);
        apply = pending && (!bus.enable || bus.resync || wrap);
    end

    // Divider, accumulator, phase counter and double-buffered configuration.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt       <= '0;
            acc       <= '0;
            stretch   <= 1'b0;
            phase     <= '0;
            act_int   <= '0;
            act_frac  <= '0;
            act_osr   <= '0;
            sh_int    <= '0;
            sh_frac   <= '0;
            sh_osr    <= '0;
            pending   <= 1'b0;
            cfg_ack_q <= 1'b0;
            baud_q    <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            baud_q    <= 1'b0;
            bit_q     <= 1'b0;
            cfg_ack_q <= apply;

            if (!bus.enable || bus.resync) begin
                // Idle or realign: restart a full period from phase 0, with
                // the new divisor already in place if one is being applied.
                cnt     <= apply ? sh_int : act_int;
                acc     <= '0;
                stretch <= 1'b0;
                phase   <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else if (tick_edge) begin
                baud_q  <= 1'b1;
                bit_q   <= wrap;
                stretch <= 1'b0;
                phase   <= wrap ? '0 : phase + OSR_W'(1);
                cnt     <= apply ? sh_int : act_int;
                if (apply) begin
                    acc <= '0;
                end else if (!stretch) begin
                    acc <= acc_sum[FRAC_W-1:0];
                end
            end else begin
                // Accumulator overflow: hold at zero for one extra cycle.
                acc     <= acc_sum[FRAC_W-1:0];
                stretch <= 1'b1;
            end

            if (apply) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
                act_osr  <= sh_osr;
                pending  <= 1'b0;
            end

            // A load on an apply edge wins: the old shadow goes active above
            // and the freshly captured value stays pending for next time.
            if (bus.cfg_load) begin
                sh_int  <= bus.cfg_int;
                sh_frac <= bus.cfg_frac;
                sh_osr  <= bus.cfg_osr;
                pending <= 1'b1;
            end
        end
    end

    assign bus.cfg_ack    = cfg_ack_q;
    assign bus.baud_tick  = baud_q;
    assign bus.bit_tick   = bit_q;
    assign bus.tick_phase = phase;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for the fractional baud generator: a table of divisor settings with
// hand-computed periods, then directed sequences for reconfiguration at a
// bit boundary, resync, load/apply collision and asynchronous reset.
module tb_uart_baud_gen_frac;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR_W  = 5;

    logic clk;
    logic aresetn;

    uart_baud_gen_frac_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)) bus ();

    uart_baud_gen_frac #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cint;
        int cfrac;
        int cosr;
        int nticks;
        int exp_cycles;
        int exp_bits;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until the next baud_tick, bounded.
    task automatic next_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.baud_tick && n < 300);
        check("tick_seen", int'(bus.baud_tick), 1);
    endtask

    // Load a configuration while disabled; it must be applied on the next edge.
    task automatic configure(input int ci, input int cf, input int co);
        bus.enable   = 1'b0;
        bus.cfg_int  = CNT_W'(ci);
        bus.cfg_frac = FRAC_W'(cf);
        bus.cfg_osr  = OSR_W'(co);
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        step();
        check("cfg_ack_disabled", int'(bus.cfg_ack), 1);
        step();
        check("no_tick_disabled", int'(bus.baud_tick), 0);
        step();
    endtask

    initial begin
        int n;
        int total;
        int bits;
        int mphase;
        int found;

        // Divisor table: periods derived from int+1 plus one stretch per
        // accumulator overflow, counted over ticks 2..nticks+1.
        vecs[0] = '{cint: 4, cfrac: 0, cosr: 15, nticks: 16, exp_cycles: 80, exp_bits: 1};
        vecs[1] = '{cint: 4, cfrac: 8, cosr: 15, nticks: 16, exp_cycles: 88, exp_bits: 1};
        vecs[2] = '{cint: 4, cfrac: 1, cosr: 15, nticks: 16, exp_cycles: 81, exp_bits: 1};
        vecs[3] = '{cint: 0, cfrac: 0, cosr: 0,  nticks: 16, exp_cycles: 16, exp_bits: 16};
        vecs[4] = '{cint: 2, cfrac: 4, cosr: 3,  nticks: 16, exp_cycles: 52, exp_bits: 4};

        // Reset block.
        aresetn      = 1'b0;
        bus.enable   = 1'b0;
        bus.cfg_int  = '0;
        bus.cfg_frac = '0;
        bus.cfg_osr  = '0;
        bus.cfg_load = 1'b0;
        bus.resync   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_baud_tick", int'(bus.baud_tick), 0);
        check("rst_bit_tick", int'(bus.bit_tick), 0);
        check("rst_cfg_ack", int'(bus.cfg_ack), 0);
        check("rst_tick_phase", int'(bus.tick_phase), 0);
        aresetn = 1'b1;
        step();

        // Table-driven period / phase checks.
        for (int i = 0; i < 5; i++) begin
            configure(vecs[i].cint, vecs[i].cfrac, vecs[i].cosr);
            bus.enable = 1'b1;
            next_tick(n);
            check($sformatf("v%0d_first_latency", i), n, vecs[i].cint + 1);
            mphase = (vecs[i].cosr == 0) ? 0 : 1;
            check($sformatf("v%0d_first_phase", i), int'(bus.tick_phase), mphase);
            total = 0;
            bits  = 0;
            for (int k = 0; k < vecs[i].nticks; k++) begin
                next_tick(n);
                total += n;
                mphase = (mphase == vecs[i].cosr) ? 0 : mphase + 1;
                check($sformatf("v%0d_phase", i), int'(bus.tick_phase), mphase);
                check($sformatf("v%0d_bit_tick", i), int'(bus.bit_tick), (mphase == 0) ? 1 : 0);
                if (bus.bit_tick) bits++;
            end
            check($sformatf("v%0d_cycles", i), total, vecs[i].exp_cycles);
            check($sformatf("v%0d_bits", i), bits, vecs[i].exp_bits);
        end

        // Reconfigure mid-bit: old period holds until the bit boundary.
        configure(4, 0, 15);
        bus.enable = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            next_tick(n);
            if (bus.tick_phase == 5) begin
                found = 1;
                break;
            end
        end
        check("t3_find_phase5", found, 1);
        bus.cfg_int  = 16'd9;
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        next_tick(n);
        n += 1;
        check("t3_period_old", n, 5);
        check("t3_no_early_ack", int'(bus.cfg_ack), 0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            next_tick(n);
            check("t3_period_old", n, 5);
            check("t3_ack_with_bit", int'(bus.cfg_ack), int'(bus.bit_tick));
            if (bus.bit_tick) begin
                found = 1;
                break;
            end
        end
        check("t3_boundary_seen", found, 1);
        next_tick(n);
        check("t3_period_new", n, 10);
        next_tick(n);
        check("t3_period_new2", n, 10);

        // Resync with cnt=2, phase=7 and a pending configuration.
        configure(4, 0, 15);
        bus.enable = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            next_tick(n);
            if (bus.tick_phase == 7) begin
                found = 1;
                break;
            end
        end
        check("t4_find_phase7", found, 1);
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        step();
        bus.resync = 1'b1;
        step();
        bus.resync = 1'b0;
        check("t4_resync_ack", int'(bus.cfg_ack), 1);
        check("t4_resync_no_tick", int'(bus.baud_tick), 0);
        check("t4_resync_phase", int'(bus.tick_phase), 0);
        next_tick(n);
        check("t4_latency", n, 5);
        check("t4_phase_after", int'(bus.tick_phase), 1);
        check("t4_no_bit", int'(bus.bit_tick), 0);

        // Load coincident with a bit-boundary apply of an earlier load.
        configure(4, 0, 3);
        bus.enable = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            next_tick(n);
            if (bus.bit_tick) begin
                found = 1;
                break;
            end
        end
        check("t5_first_boundary", found, 1);
        bus.cfg_int  = 16'd3;
        bus.cfg_osr  = 5'd3;
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            next_tick(n);
            if (bus.tick_phase == 3) begin
                found = 1;
                break;
            end
        end
        check("t5_find_phase3", found, 1);
        repeat (4) step();
        bus.cfg_int  = 16'd7;
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        check("t5_apply_baud", int'(bus.baud_tick), 1);
        check("t5_apply_bit", int'(bus.bit_tick), 1);
        check("t5_apply_ack", int'(bus.cfg_ack), 1);
        for (int k = 0; k < 4; k++) begin
            next_tick(n);
            check("t5_period_int3", n, 4);
            check("t5_second_ack", int'(bus.cfg_ack), (k == 3) ? 1 : 0);
            check("t5_bit", int'(bus.bit_tick), (k == 3) ? 1 : 0);
        end
        next_tick(n);
        check("t5_period_int7", n, 8);

        // Asynchronous reset while a tick is high and a load is pending.
        bus.cfg_int  = 16'd2;
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        next_tick(n);
        check("t6_tick_before_reset", int'(bus.baud_tick), 1);
        #1;
        aresetn = 1'b0;
        #1;
        check("t6_async_baud", int'(bus.baud_tick), 0);
        check("t6_async_bit", int'(bus.bit_tick), 0);
        check("t6_async_ack", int'(bus.cfg_ack), 0);
        check("t6_async_phase", int'(bus.tick_phase), 0);
        bus.enable = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_no_ack_after_reset", int'(bus.cfg_ack), 0);
            check("t6_no_tick_disabled", int'(bus.baud_tick), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
